mem_responder: RTL

- Data-memory target for the multi-cycle RV32 core. It answers the load/store requests the core issues in its memory-access stage.
- Holds a word-organised RAM with per-byte write enables.
- Inserts a programmable number of wait states, asserting MEMWAIT so the stage clock generator stalls until the access completes.
- Returns read data with a one-cycle RVALID pulse and flags out-of-range addresses.

---
 rtl/mem_pkg.sv | 19 +
 rtl/bram_be.sv | 28 ++
 rtl/mem_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and widths for the data-memory responder.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Request fields captured on the accept edge (word address kept separately,
  // its width depends on the RAM depth).
  typedef struct packed {
    logic [WORD_W-1:0] wdata;
    logic [LANES-1:0]  be;
    logic              we;
    logic              oor;
  } req_t;

endpackage

// File: rtl/bram_be.sv
// Single-port synchronous RAM, byte write enables, registered read.
// Contents are intentionally not reset.
module bram_be
  import mem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LANES-1:0]  be,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [LANES-1:0][7:0] mem [2**ADDR_W];

  // Per-lane write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int n = 0; n < LANES; n++)
        if (be[n]) mem[addr][n] <= wdata[8*n +: 8];
    end
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Data-memory target for the multi-cycle core: wait-state insertion,
// byte-enabled stores, range checking, one-cycle completion pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic [31:0]       ADDR,
  input  logic [WORD_W-1:0] WDATA,
  input  logic [LANES-1:0]  BYTEENA,
  input  logic              WE,
  output logic              MEMWAIT,
  output logic [WORD_W-1:0] RDATA,
  output logic              RVALID,
  output logic              ERR
);

  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be 0..15");
  end
  if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
    $error("mem_responder: ADDR_W must be 1..29");
  end

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  req_t              req_q, req_in, req_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [WORD_W-1:0] ram_q, rdata_q;
  logic              err_q, done_ld;
  logic              accept, access;

  // Word-access only: the byte offset never matters.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ADDR[1:0];

  assign accept = (state == IDLE) && REQ;

  // With zero latency the access happens on the accept edge itself, so the
  // RAM is fed straight from the inputs while idle, else from the latched request.
  always_comb begin
    req_in.wdata = WDATA;
    req_in.be    = BYTEENA;
    req_in.we    = WE;
    req_in.oor   = |ADDR[31:ADDR_W+2];
    req_sel      = (state == IDLE) ? req_in : req_q;
    addr_sel     = (state == IDLE) ? ADDR[ADDR_W+1:2] : addr_q;
    access       = (accept && LATENCY == 0) || (state == BUSY && cnt == '0);
  end

  bram_be #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (CLK),
    .wr_en (access && req_sel.we && !req_sel.oor),
    .rd_en (access && !req_sel.we && !req_sel.oor),
    .addr  (addr_sel),
    .be    (req_sel.be),
    .wdata (req_sel.wdata),
    .rdata (ram_q)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (REQ) state_nxt = (LATENCY == 0) ? DONE : BUSY;
      BUSY: if (cnt == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: stall while a request is pending, live RAM data during DONE,
  // held copy afterwards.
  always_comb begin
    MEMWAIT = accept || (state == BUSY);
    RVALID  = (state == DONE);
    ERR     = err_q;
    RDATA   = rdata_q;
    if (state == DONE) RDATA = done_ld ? ram_q : '0;
  end

  // Request capture, wait counter and completion status.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt     <= '0;
      addr_q  <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
      done_ld <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= ADDR[ADDR_W+1:2];
        req_q  <= req_in;
        cnt    <= CNT_W'(LATENCY - 1);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      err_q   <= access ? req_sel.oor : 1'b0;
      if (access) done_ld <= !req_sel.we && !req_sel.oor;
      if (state == DONE) rdata_q <= RDATA;
    end
  end

endmodule
